// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a (no data path).
package btn_pkg;

  // Per-channel debounce/hold FSM states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_WAIT = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG       = 3'd3,
    ST_REL_WAIT   = 3'd4
  } btn_fsm_e;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int btn_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clock cycles per debounce tick; clamped so the prescaler always exists.
  function automatic int btn_tick_cycles(input int clk_hz, input int tick_us);
    int t;
    t = (clk_hz / 1000000) * tick_us;
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold/repeat counters.
// Latency: 2 cycles sync + DEBOUNCE_TICKS ticks to accept; events registered (1 cycle).
// Backpressure: none; events are single-cycle pulses that cannot be stalled.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter logic ACTIVE_STATE   = 1'b1,
  parameter int   DEBOUNCE_TICKS = 20,
  parameter int   LONG_TICKS     = 1000,
  parameter int   REPEAT_TICKS   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_state,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt,
  output logic repeat_evt,
  output logic release_was_long
);

  localparam int DCNT_W = btn_clog2(DEBOUNCE_TICKS + 1);
  localparam int HCNT_W = btn_clog2(btn_max(LONG_TICKS, REPEAT_TICKS) + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_TICKS - 1);
  // With repeat disabled this value is never compared against.
  localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  btn_fsm_e          state_q, state_d;
  logic              ret_long_q, ret_long_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  logic              rwl_q, rwl_d;
  logic              a;

  // Next-state logic: synchroniser shift, FSM transitions, counters and event pulses.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    a          = (sync2_q == ACTIVE_STATE);
    state_d    = state_q;
    ret_long_d = ret_long_q;
    dcnt_d     = dcnt_q;
    hcnt_d     = hcnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    rwl_d      = 1'b0;

    // A change of 'a' always wins over a coincident tick.
    case (state_q)
      ST_IDLE: begin
        if (a) begin
          state_d = ST_PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!a) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (dcnt_q == DCNT_LAST) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
            level_d = 1'b1;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
        end
      end
      ST_PRESSED: begin
        if (!a) begin
          state_d    = ST_REL_WAIT;
          dcnt_d     = '0;
          ret_long_d = 1'b0;
        end else if (tick) begin
          if (hcnt_q == LONG_LAST) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end
      end
      ST_LONG: begin
        if (!a) begin
          state_d    = ST_REL_WAIT;
          dcnt_d     = '0;
          ret_long_d = 1'b1;
        end else if (tick && (REPEAT_TICKS != 0)) begin
          if (hcnt_q == REP_LAST) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end
      end
      ST_REL_WAIT: begin
        // hcnt is left untouched here so a release bounce resumes the hold.
        if (a) begin
          state_d = ret_long_q ? ST_LONG : ST_PRESSED;
        end else if (tick) begin
          if (dcnt_q == DCNT_LAST) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
            rwl_d     = ret_long_q;
            level_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; sync flops park at the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= ~ACTIVE_STATE;
      sync2_q    <= ~ACTIVE_STATE;
      state_q    <= ST_IDLE;
      ret_long_q <= 1'b0;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      rwl_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      ret_long_q <= ret_long_d;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      rwl_q      <= rwl_d;
    end
  end

  assign btn_state        = level_q;
  assign press_evt        = press_q;
  assign release_evt      = release_q;
  assign long_evt         = long_q;
  assign repeat_evt       = repeat_q;
  assign release_was_long = rwl_q;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Multi-button controller: shared tick prescaler feeding NUM_BTNS debounce channels.
// Latency: 2-cycle sync + DEBOUNCE_TICKS ticks; events are registered 1-cycle pulses.
// Backpressure: none; outputs are free-running pulses and levels.
module btn_debounce_ctrl
  import btn_pkg::*;
#(
  parameter int   NUM_BTNS       = 4,
  parameter logic ACTIVE_STATE   = 1'b1,
  parameter int   CLK_HZ         = 50000000,
  parameter int   TICK_US        = 1000,
  parameter int   DEBOUNCE_TICKS = 20,
  parameter int   LONG_TICKS     = 1000,
  parameter int   REPEAT_TICKS   = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic [NUM_BTNS-1:0] press_evt,
  output logic [NUM_BTNS-1:0] release_evt,
  output logic [NUM_BTNS-1:0] long_evt,
  output logic [NUM_BTNS-1:0] repeat_evt,
  output logic [NUM_BTNS-1:0] release_was_long
);

  localparam int TICK_CYCLES = btn_tick_cycles(CLK_HZ, TICK_US);
  localparam int PCNT_W      = btn_clog2(TICK_CYCLES);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_CYCLES - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              tick_q, tick_d;

  // Prescaler: count 0..TICK_CYCLES-1 and flag the wrap as next cycle's tick.
  always_comb begin
    tick_d = (pcnt_q == PCNT_LAST);
    pcnt_d = tick_d ? '0 : pcnt_q + PCNT_W'(1);
  end

  // Prescaler registers; first tick lands TICK_CYCLES cycles after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    btn_debounce_chan #(
      .ACTIVE_STATE  (ACTIVE_STATE),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_chan (
      .clk             (clk),
      .rst_n           (rst_n),
      .tick            (tick_q),
      .btn_raw         (btn_in[g]),
      .btn_state       (btn_state[g]),
      .press_evt       (press_evt[g]),
      .release_evt     (release_evt[g]),
      .long_evt        (long_evt[g]),
      .repeat_evt      (repeat_evt[g]),
      .release_was_long(release_was_long[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Self-checking bench for btn_debounce_ctrl against a stability-count reference model.
// Latency: model tracks 2-cycle input sync and tick timing explicitly.
// Backpressure: n/a.
module tb_btn_debounce_ctrl;

  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int REP  = 5;
  localparam int TPER = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_state, press_evt, release_evt, long_evt, repeat_evt, release_was_long;

  always #5 clk = ~clk;

  btn_debounce_ctrl #(
    .NUM_BTNS      (NB),
    .ACTIVE_STATE  (1'b1),
    .CLK_HZ        (1000000),
    .TICK_US       (10),
    .DEBOUNCE_TICKS(DEB),
    .LONG_TICKS    (LNG),
    .REPEAT_TICKS  (REP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_in          (btn_in),
    .btn_state       (btn_state),
    .press_evt       (press_evt),
    .release_evt     (release_evt),
    .long_evt        (long_evt),
    .repeat_evt      (repeat_evt),
    .release_was_long(release_was_long)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: accepted level per channel plus counts of stable ticks.
  int          m_edge;
  bit          m_s1[NB], m_s2[NB], m_prev_a[NB], m_lvl[NB], m_long[NB];
  int          m_d[NB], m_h[NB];
  logic [NB-1:0] x_state, x_press, x_rel, x_long, x_rep, x_rwl;
  logic        x_tick;

  // Observed event counters for scenario-level checks.
  int ob_press[NB], ob_rel[NB], ob_long[NB], ob_rep[NB], ob_rwl[NB];
  int ob_tick, ob_both;

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      ob_press[c] = 0; ob_rel[c] = 0; ob_long[c] = 0; ob_rep[c] = 0; ob_rwl[c] = 0;
    end
    ob_tick = 0;
    ob_both = 0;
  endtask

  task automatic model_edge(input logic rst_v, input logic [NB-1:0] btn_v);
    bit a, changed, tk;
    x_press = '0; x_rel = '0; x_long = '0; x_rep = '0; x_rwl = '0;
    if (!rst_v) begin
      m_edge = 0;
      x_tick = 1'b0;
      x_state = '0;
      for (int c = 0; c < NB; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_prev_a[c] = 0; m_lvl[c] = 0; m_long[c] = 0;
        m_d[c] = 0; m_h[c] = 0;
      end
      return;
    end
    m_edge++;
    tk     = x_tick;
    x_tick = (m_edge % TPER == 0);
    for (int c = 0; c < NB; c++) begin
      a           = m_s2[c];
      m_s2[c]     = m_s1[c];
      m_s1[c]     = btn_v[c];
      changed     = (a != m_prev_a[c]);
      m_prev_a[c] = a;
      if (a != m_lvl[c]) begin
        if (changed) m_d[c] = 0;
        else if (tk) begin
          m_d[c]++;
          if (m_d[c] == DEB) begin
            if (!m_lvl[c]) begin
              m_lvl[c] = 1; m_h[c] = 0; m_long[c] = 0; x_press[c] = 1'b1;
            end else begin
              m_lvl[c] = 0; x_rel[c] = 1'b1; x_rwl[c] = m_long[c]; m_long[c] = 0; m_h[c] = 0;
            end
            x_state[c] = m_lvl[c];
          end
        end
      end else if (!changed && tk && m_lvl[c]) begin
        m_h[c]++;
        if (!m_long[c]) begin
          if (m_h[c] == LNG) begin
            m_long[c] = 1; m_h[c] = 0; x_long[c] = 1'b1;
          end
        end else if (m_h[c] == REP) begin
          m_h[c] = 0; x_rep[c] = 1'b1;
        end
      end
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs compared 1ns later.
  task automatic step();
    logic r;
    logic [NB-1:0] b;
    r = rst_n;
    b = btn_in;
    @(posedge clk);
    model_edge(r, b);
    #1;
    chk("tick",             32'(dut.tick_q),        32'(x_tick));
    chk("btn_state",        32'(btn_state),         32'(x_state));
    chk("press_evt",        32'(press_evt),         32'(x_press));
    chk("release_evt",      32'(release_evt),       32'(x_rel));
    chk("long_evt",         32'(long_evt),          32'(x_long));
    chk("repeat_evt",       32'(repeat_evt),        32'(x_rep));
    chk("release_was_long", 32'(release_was_long),  32'(x_rwl));
    ob_tick += int'(dut.tick_q);
    if (press_evt == 2'b11) ob_both++;
    for (int c = 0; c < NB; c++) begin
      ob_press[c] += int'(press_evt[c]);
      ob_rel[c]   += int'(release_evt[c]);
      ob_long[c]  += int'(long_evt[c]);
      ob_rep[c]   += int'(repeat_evt[c]);
      ob_rwl[c]   += int'(release_evt[c] & release_was_long[c]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the DUT tick is seen; bounded so a dead prescaler cannot hang the run.
  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (dut.tick_q !== 1'b1 && k < 40);
    chk("wait_tick", 32'(dut.tick_q), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = '0;
    run(3);
    rst_n = 1'b1;

    // 1: idle after reset, ticks every 10 cycles
    clear_counts();
    run(500);
    chk("s1_ticks", 32'(ob_tick), 32'd50);
    chk("s1_no_events", 32'(ob_press[0] + ob_press[1] + ob_rel[0] + ob_rel[1] + ob_long[0] + ob_rep[0]), 32'd0);

    // 2: bouncing press on btn0 settles into one press
    clear_counts();
    for (int i = 0; i < 7; i++) begin
      btn_in[0] = ~btn_in[0];
      run($urandom_range(3, 25));
    end
    run(80);
    chk("s2_press_once", 32'(ob_press[0]), 32'd1);
    chk("s2_state", 32'(btn_state[0]), 32'd1);
    chk("s2_btn1_quiet", 32'(ob_press[1] + ob_rel[1]), 32'd0);
    btn_in[0] = 1'b0;
    run(80);
    chk("s2_release", 32'(ob_rel[0]), 32'd1);

    // 3: 35-cycle glitch spans only 3 ticks
    wait_tick();
    clear_counts();
    btn_in[0] = 1'b1;
    run(35);
    btn_in[0] = 1'b0;
    run(60);
    chk("s3_no_press", 32'(ob_press[0]), 32'd0);
    chk("s3_state", 32'(btn_state[0]), 32'd0);

    // 4: long hold with auto-repeat, then long release
    wait_tick();
    clear_counts();
    btn_in[0] = 1'b1;
    run(3000);
    chk("s4_long", 32'(ob_long[0]), 32'd1);
    chk("s4_repeats", 32'(ob_rep[0]), 32'd55);
    btn_in[0] = 1'b0;
    run(60);
    chk("s4_release", 32'(ob_rel[0]), 32'd1);
    chk("s4_rel_was_long", 32'(ob_rwl[0]), 32'd1);

    // 5a: short press releases as not-long
    wait_tick();
    clear_counts();
    btn_in[0] = 1'b1;
    run(100);
    btn_in[0] = 1'b0;
    run(70);
    chk("s5_release", 32'(ob_rel[0]), 32'd1);
    chk("s5_not_long", 32'(ob_rwl[0]), 32'd0);

    // 5b: 2-tick release bounce mid-hold is swallowed
    clear_counts();
    btn_in[0] = 1'b1;
    run(150);
    btn_in[0] = 1'b0;
    run(20);
    btn_in[0] = 1'b1;
    run(60);
    chk("s5_bounce_no_rel", 32'(ob_rel[0]), 32'd0);
    chk("s5_bounce_one_press", 32'(ob_press[0]), 32'd1);
    run(200);
    chk("s5_long_after_bounce", 32'(ob_long[0]), 32'd1);
    btn_in[0] = 1'b0;
    run(70);

    // 6: simultaneous press, then reset mid-hold
    clear_counts();
    btn_in = 2'b11;
    run(100);
    chk("s6_both_press", 32'(ob_both), 32'd1);
    rst_n = 1'b0;
    run(2);
    chk("s6_reset_state", 32'(btn_state), 32'd0);
    btn_in = 2'b00;
    run(1);
    rst_n = 1'b1;
    run(60);
    chk("s6_no_release", 32'(ob_rel[0] + ob_rel[1]), 32'd0);

    // Random toggling on both channels
    for (int s = 0; s < 70; s++) begin
      btn_in[$urandom_range(0, NB - 1)] ^= 1'b1;
      run($urandom_range(1, 80));
    end
    btn_in = '0;
    run(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
